// File: rtl/mcav_pkg.sv
// Shared definitions for the 9-bit processor control sequencer: FSM states,
// instruction field layout and ALU opcode / compare-result encodings.
package mcav_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] TYPE_MATH   = 2'b00;
    localparam logic [1:0] TYPE_BRANCH = 2'b01;
    localparam logic [1:0] TYPE_ASSIGN = 2'b10;
    localparam logic [1:0] TYPE_VALUE  = 2'b11;

    // Math ops whose carry-out is architecturally visible
    localparam logic [2:0] M_OP_CARRY_A = 3'b000;
    localparam logic [2:0] M_OP_CARRY_B = 3'b001;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;
    localparam logic [1:0] CMP_NE = 2'b11;

    localparam logic [2:0] A_OP_CMP = 3'b100;
    localparam logic       V_OP_MOV = 1'b0;
    localparam logic       V_OP_NOP = 1'b1;

    localparam logic [8:0] HALT_INSTR = 9'h0FF;
    localparam logic [1:0] FLAG_RESET = CMP_NE;

    localparam int IR_TYPE_HI = 8;
    localparam int IR_TYPE_LO = 7;
    localparam int IR_OP3_HI  = 6;
    localparam int IR_OP3_LO  = 4;
    localparam int IR_COP_HI  = 6;
    localparam int IR_COP_LO  = 5;
    localparam int IR_IDX_HI  = 4;
    localparam int IR_IDX_LO  = 0;
    localparam int IR_REG_HI  = 3;
    localparam int IR_REG_LO  = 0;
    localparam int IR_VOP     = 6;

    function automatic logic updates_carry(input logic [2:0] m_op);
        return (m_op == M_OP_CARRY_A) || (m_op == M_OP_CARRY_B);
    endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Instruction-memory, ALU, register-file and jump-LUT signals between the
// sequencer (master) and the datapath around it (slave).
interface ctrl_seq_if #(
    parameter int PC_W  = 8,
    parameter int LUT_W = 5
) ();
    logic [PC_W-1:0]  imem_addr;
    logic [8:0]       imem_data;
    logic             imem_valid;
    logic [1:0]       alu_type;
    logic [2:0]       alu_m_op;
    logic [1:0]       alu_c_op;
    logic [2:0]       alu_a_op;
    logic             alu_v_op;
    logic             alu_sc_i;
    logic             alu_sc_o;
    logic [1:0]       alu_cmp_src;
    logic [3:0]       rf_raddr_a;
    logic [3:0]       rf_raddr_b;
    logic [3:0]       rf_waddr;
    logic             rf_we;
    logic [LUT_W-1:0] lut_idx;
    logic [PC_W-1:0]  lut_target;

    modport master (
        output imem_addr, alu_type, alu_m_op, alu_c_op, alu_a_op, alu_v_op,
               alu_sc_i, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, lut_idx,
        input  imem_data, imem_valid, alu_sc_o, alu_cmp_src, lut_target
    );

    modport slave (
        input  imem_addr, alu_type, alu_m_op, alu_c_op, alu_a_op, alu_v_op,
               alu_sc_i, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, lut_idx,
        output imem_data, imem_valid, alu_sc_o, alu_cmp_src, lut_target
    );
endinterface

// File: rtl/ctrl_seq_branch_eval.sv
// Branch resolution: a branch is taken when the stored compare flag equals
// the instruction's condition op; otherwise execution falls through.
module branch_eval #(
    parameter int PC_W = 8
) (
    input  logic [1:0]      c_op,
    input  logic [1:0]      cmp_flag,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] lut_target,
    output logic            taken,
    output logic [PC_W-1:0] next_pc
);
    assign taken   = (cmp_flag == c_op);
    assign next_pc = taken ? lut_target : (pc + PC_W'(1));
endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 9-bit processor; owns
// the PC, the carry and compare flags, and issues ALU and register-file commands.
module ctrl_seq
    import mcav_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int LUT_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          done,
    ctrl_seq_if.master    bus
);
    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, pc_inc_s, br_next_pc_s;
    logic [8:0]       ir_q, ir_d;
    logic             carry_q, carry_d, done_q, done_d, rf_we_q, rf_we_d, br_taken_s;
    logic [1:0]       cmp_flag_q, cmp_flag_d, type_q, type_d, c_op_q, c_op_d, ir_type_s;
    logic [2:0]       m_op_q, m_op_d, a_op_q, a_op_d;
    logic             v_op_q, v_op_d;
    logic [3:0]       raddr_a_q, raddr_a_d, raddr_b_q, raddr_b_d;
    logic [3:0]       rf_waddr_q, rf_waddr_d, ir_reg_s;
    logic [LUT_W-1:0] lut_idx_q, lut_idx_d;

    assign ir_type_s = ir_q[IR_TYPE_HI:IR_TYPE_LO];
    assign ir_reg_s  = ir_q[IR_REG_HI:IR_REG_LO];
    assign pc_inc_s  = pc_q + PC_W'(1);

    branch_eval #(.PC_W(PC_W)) u_branch_eval (
        .c_op       (c_op_q),
        .cmp_flag   (cmp_flag_q),
        .pc         (pc_q),
        .lut_target (bus.lut_target),
        .taken      (br_taken_s),
        .next_pc    (br_next_pc_s)
    );

    // Next-state, PC, flag and command-field computation
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        carry_d    = carry_q;
        cmp_flag_d = cmp_flag_q;
        done_d     = done_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        type_d     = type_q;
        m_op_d     = m_op_q;
        c_op_d     = c_op_q;
        a_op_d     = a_op_q;
        v_op_d     = v_op_q;
        raddr_a_d  = raddr_a_q;
        raddr_b_d  = raddr_b_q;
        lut_idx_d  = lut_idx_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    done_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH: begin
                if (bus.imem_valid) begin
                    ir_d    = bus.imem_data;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // Fields not belonging to the instruction's type are zeroed
                type_d    = ir_type_s;
                m_op_d    = 3'b000;
                c_op_d    = 2'b00;
                a_op_d    = 3'b000;
                v_op_d    = 1'b0;
                lut_idx_d = '0;
                raddr_a_d = ir_reg_s;
                raddr_b_d = 4'h0;
                case (ir_type_s)
                    TYPE_MATH: m_op_d = ir_q[IR_OP3_HI:IR_OP3_LO];
                    TYPE_BRANCH: begin
                        c_op_d    = ir_q[IR_COP_HI:IR_COP_LO];
                        lut_idx_d = LUT_W'(ir_q[IR_IDX_HI:IR_IDX_LO]);
                        raddr_a_d = 4'h0;
                    end
                    TYPE_ASSIGN: begin
                        a_op_d = ir_q[IR_OP3_HI:IR_OP3_LO];
                        if (ir_q[IR_OP3_HI:IR_OP3_LO] == A_OP_CMP) begin
                            raddr_a_d = 4'h0;
                            raddr_b_d = ir_reg_s;
                        end else begin
                            raddr_b_d = 4'h0;
                        end
                    end
                    TYPE_VALUE: begin
                        v_op_d = ir_q[IR_VOP];
                        if (ir_q[IR_VOP] == V_OP_MOV) begin
                            raddr_a_d = 4'h0;
                        end else begin
                            raddr_a_d = ir_reg_s;
                        end
                    end
                    default: type_d = ir_type_s;
                endcase
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (ir_q == HALT_INSTR) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    case (type_q)
                        TYPE_BRANCH: pc_d = br_taken_s ? br_next_pc_s : pc_inc_s;
                        TYPE_ASSIGN: begin
                            if (a_op_q == A_OP_CMP) begin
                                cmp_flag_d = bus.alu_cmp_src;
                            end else begin
                                cmp_flag_d = cmp_flag_q;
                            end
                            pc_d = pc_inc_s;
                        end
                        TYPE_MATH: begin
                            if (updates_carry(m_op_q)) begin
                                carry_d = bus.alu_sc_o;
                            end else begin
                                carry_d = carry_q;
                            end
                            rf_we_d    = 1'b1;
                            rf_waddr_d = 4'h0;
                            state_d    = ST_WB;
                        end
                        TYPE_VALUE: begin
                            if (v_op_q == V_OP_MOV) begin
                                rf_we_d    = 1'b1;
                                rf_waddr_d = ir_reg_s;
                                state_d    = ST_WB;
                            end else begin
                                pc_d = pc_inc_s;
                            end
                        end
                        default: state_d = ST_FETCH;
                    endcase
                end
            end
            ST_WB: begin
                pc_d    = pc_inc_s;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= 9'h000;
            carry_q    <= 1'b0;
            cmp_flag_q <= FLAG_RESET;
            done_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 4'h0;
            type_q     <= 2'b00;
            m_op_q     <= 3'b000;
            c_op_q     <= 2'b00;
            a_op_q     <= 3'b000;
            v_op_q     <= 1'b0;
            raddr_a_q  <= 4'h0;
            raddr_b_q  <= 4'h0;
            lut_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            carry_q    <= carry_d;
            cmp_flag_q <= cmp_flag_d;
            done_q     <= done_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            type_q     <= type_d;
            m_op_q     <= m_op_d;
            c_op_q     <= c_op_d;
            a_op_q     <= a_op_d;
            v_op_q     <= v_op_d;
            raddr_a_q  <= raddr_a_d;
            raddr_b_q  <= raddr_b_d;
            lut_idx_q  <= lut_idx_d;
        end
    end

    assign done           = done_q;
    assign bus.imem_addr  = pc_q;
    assign bus.alu_type   = type_q;
    assign bus.alu_m_op   = m_op_q;
    assign bus.alu_c_op   = c_op_q;
    assign bus.alu_a_op   = a_op_q;
    assign bus.alu_v_op   = v_op_q;
    assign bus.alu_sc_i   = carry_q;
    assign bus.rf_raddr_a = raddr_a_q;
    assign bus.rf_raddr_b = raddr_b_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.lut_idx    = lut_idx_q;

endmodule
